baccarat_wager_ctrl: RTL and testbench

BACCARAT_WAGER_CTRL -- requirements
Module: baccarat_wager_ctrl

---
 rtl/baccarat_pkg.sv | 26 ++
 rtl/baccarat_draw_rule.sv | 20 ++
 rtl/baccarat_wager_ctrl.sv | 157 +++++++++++++++
 tb/tb_baccarat_wager_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat wager controller: FSM states, result and bet-side codes.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_WAGER, S_P1, S_D1, S_P2, S_D2,
        S_DECIDE, S_P3, S_DECIDE_B, S_D3, S_SCORE, S_SETTLE
    } state_t;

    // Side codes share the result encoding so a matching bet is a plain equality.
    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_BANKER = 2'b10;
    localparam logic [1:0] RES_TIE    = 2'b11;

    localparam logic [1:0] SIDE_NONE   = 2'b00;
    localparam logic [1:0] SIDE_PLAYER = 2'b01;
    localparam logic [1:0] SIDE_BANKER = 2'b10;
    localparam logic [1:0] SIDE_TIE    = 2'b11;

    function automatic logic [1:0] hand_result(input logic [3:0] p, input logic [3:0] d);
        if (p > d)      return RES_PLAYER;
        else if (p < d) return RES_BANKER;
        else            return RES_TIE;
    endfunction

endpackage

// File: rtl/baccarat_draw_rule.sv
// Banker third-card rule: decides from the banker score and the player's third card.
module baccarat_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3 != 4'd8);
            4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_wager_ctrl.sv
// Baccarat round sequencer: takes a wager, deals via load strobes, scores and settles the balance.
//   state    | meaning
//   IDLE     | waiting for start (ignored when bankrupt)
//   WAGER    | latch and validate bet
//   P1..D2   | initial four card loads
//   DECIDE   | natural / player draw / banker-only draw
//   P3       | player third card
//   DECIDE_B | banker third-card table
//   D3       | banker third card
//   SCORE    | register result
//   SETTLE   | update balance, pulse done
module baccarat_wager_ctrl
    import baccarat_pkg::*;
#(
    parameter int BAL_W    = 8,
    parameter int BET_W    = 4,
    parameter int INIT_BAL = 100,
    parameter int TIE_MULT = 8
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [1:0]       bet_side,
    input  logic [BET_W-1:0] bet_amt,
    input  logic [3:0]       pscore,
    input  logic [3:0]       dscore,
    input  logic [3:0]       pcard3,
    output logic             load_pcard1,
    output logic             load_pcard2,
    output logic             load_pcard3,
    output logic             load_dcard1,
    output logic             load_dcard2,
    output logic             load_dcard3,
    output logic [1:0]       result,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             done,
    output logic             bet_reject,
    output logic             bankrupt
);

    localparam int SUM_W = BAL_W + BET_W + 8;
    localparam logic [SUM_W-1:0] BAL_MAX = (SUM_W'(1) << BAL_W) - SUM_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         side_q, side_d;
    logic [BET_W-1:0]   amt_q, amt_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [1:0]         result_q, result_d;
    logic               done_q, done_d;
    logic               reject_q, reject_d;

    logic               banker_draw;
    logic               wager_ok;
    logic [SUM_W-1:0]   credit_w, sum_w;

    baccarat_draw_rule u_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    assign wager_ok = (bet_side != SIDE_NONE) && (bet_amt != '0) &&
                      (SUM_W'(bet_amt) <= SUM_W'(balance_q));

    assign credit_w = (side_q == SIDE_TIE) ? SUM_W'(amt_q) * SUM_W'(TIE_MULT) : SUM_W'(amt_q);
    assign sum_w    = SUM_W'(balance_q) + credit_w;

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        amt_d     = amt_q;
        balance_d = balance_q;
        result_d  = result_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !bankrupt) begin
                    state_d  = S_WAGER;
                    result_d = RES_NONE;
                end
            end
            S_WAGER: begin
                side_d = bet_side;
                amt_d  = bet_amt;
                if (wager_ok) begin
                    state_d = S_P1;
                end else begin
                    state_d  = S_IDLE;
                    reject_d = 1'b1;
                end
            end
            S_P1: state_d = S_D1;
            S_D1: state_d = S_P2;
            S_P2: state_d = S_D2;
            S_D2: state_d = S_DECIDE;
            S_DECIDE: begin
                if (pscore >= 4'd8 || dscore >= 4'd8) state_d = S_SCORE;
                else if (pscore <= 4'd5)              state_d = S_P3;
                else if (dscore <= 4'd5)              state_d = S_D3;
                else                                  state_d = S_SCORE;
            end
            S_P3:       state_d = S_DECIDE_B;
            S_DECIDE_B: state_d = banker_draw ? S_D3 : S_SCORE;
            S_D3:       state_d = S_SCORE;
            S_SCORE: begin
                result_d = hand_result(pscore, dscore);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // Debit cannot underflow: the wager was checked against this balance.
                if (side_q == result_q)
                    balance_d = (sum_w > BAL_MAX) ? BAL_W'(BAL_MAX) : BAL_W'(sum_w);
                else if (result_q != RES_TIE)
                    balance_d = balance_q - BAL_W'(amt_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            side_q    <= SIDE_NONE;
            amt_q     <= '0;
            balance_q <= BAL_W'(INIT_BAL);
            result_q  <= RES_NONE;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            amt_q     <= amt_d;
            balance_q <= balance_d;
            result_q  <= result_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

    assign load_pcard1 = (state_q == S_P1);
    assign load_dcard1 = (state_q == S_D1);
    assign load_pcard2 = (state_q == S_P2);
    assign load_dcard2 = (state_q == S_D2);
    assign load_pcard3 = (state_q == S_P3);
    assign load_dcard3 = (state_q == S_D3);
    assign busy        = (state_q != S_IDLE);
    assign bankrupt    = (balance_q == '0);
    assign done        = done_q;
    assign bet_reject  = reject_q;
    assign result      = result_q;
    assign balance     = balance_q;

endmodule

// File: tb/tb_baccarat_wager_ctrl.sv
// Self-checking bench for baccarat_wager_ctrl: vector table plus hand sequences, scoreboard on done/reject.
module tb_baccarat_wager_ctrl;
    import baccarat_pkg::*;

    logic       clk = 1'b0;
    logic       resetb, start;
    logic [1:0] bet_side;
    logic [3:0] bet_amt, pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [1:0] result;
    logic [7:0] balance;
    logic       busy, done, bet_reject, bankrupt;

    always #5 clk = ~clk;

    baccarat_wager_ctrl #(.BAL_W(8), .BET_W(4), .INIT_BAL(100), .TIE_MULT(8)) dut (
        .slow_clock (clk),
        .resetb     (resetb),
        .start      (start),
        .bet_side   (bet_side),
        .bet_amt    (bet_amt),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard3     (pcard3),
        .load_pcard1(load_pcard1),
        .load_pcard2(load_pcard2),
        .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1),
        .load_dcard2(load_dcard2),
        .load_dcard3(load_dcard3),
        .result     (result),
        .balance    (balance),
        .busy       (busy),
        .done       (done),
        .bet_reject (bet_reject),
        .bankrupt   (bankrupt)
    );

    typedef struct {
        logic [1:0] side;
        logic [3:0] amt, p0, d0, pc3, pf, df;
        logic       pdraw, ddraw;
        logic [1:0] res;
        logic       rst;
    } vec_t;

    typedef struct {
        logic       rej;
        logic [1:0] res;
        logic [7:0] bal;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[14];
    int   total = 0;
    int   bad   = 0;
    int   model_bal = 100;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] side, input logic [3:0] amt,
                                input logic [3:0] p0, input logic [3:0] d0, input logic [3:0] pc3,
                                input logic [3:0] pf, input logic [3:0] df,
                                input logic pdraw, input logic ddraw,
                                input logic [1:0] res, input logic rst);
        vec_t v;
        v.side = side; v.amt = amt; v.p0 = p0; v.d0 = d0; v.pc3 = pc3;
        v.pf = pf; v.df = df; v.pdraw = pdraw; v.ddraw = ddraw; v.res = res; v.rst = rst;
        return v;
    endfunction

    function automatic int settle(input int bal, input logic [1:0] side,
                                  input logic [3:0] amt, input logic [1:0] res);
        int n;
        if (side == res) begin
            n = bal + ((side == 2'b11) ? 8 * int'(amt) : int'(amt));
            if (n > 255) n = 255;
        end else if (res == 2'b11) begin
            n = bal;
        end else begin
            n = bal - int'(amt);
        end
        return n;
    endfunction

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_event", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("event_is_reject", int'(bet_reject), int'(e.rej));
            if (!e.rej) check("result", int'(result), int'(e.res));
            check("balance", int'(balance), int'(e.bal));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetb = 1'b0;
        start  = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_balance", int'(balance), 100);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'(done) + int'(bet_reject) + int'(bankrupt), 0);
        check("rst_strobes", int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3) +
                             int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3), 0);
        sb_q.delete();
        model_bal = 100;
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic do_round(input vec_t v, input bit abort);
        int  seq, seq_exp, nstb, ndone;
        bit  fin, aborted, valid;
        sb_t e;
        valid = (v.side != 2'b00) && (v.amt != 4'd0) && (int'(v.amt) <= model_bal);
        e.rej = !valid;
        e.res = v.res;
        e.bal = valid ? 8'(settle(model_bal, v.side, v.amt, v.res)) : 8'(model_bal);
        sb_q.push_back(e);
        model_bal = int'(e.bal);
        seq_exp = 0;
        if (valid) begin
            seq_exp = ((1 * 8 + 2) * 8 + 3) * 8 + 4;
            if (v.pdraw) seq_exp = seq_exp * 8 + 5;
            if (v.ddraw) seq_exp = seq_exp * 8 + 6;
        end

        @(negedge clk);
        bet_side = v.side; bet_amt = v.amt;
        pscore = v.p0; dscore = v.d0; pcard3 = v.pc3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        seq = 0; fin = 0; aborted = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            nstb = int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3) +
                   int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3);
            if (nstb > 1)         seq = seq * 8 + 7;
            else if (load_pcard1) seq = seq * 8 + 1;
            else if (load_dcard1) seq = seq * 8 + 2;
            else if (load_pcard2) seq = seq * 8 + 3;
            else if (load_dcard2) seq = seq * 8 + 4;
            else if (load_pcard3) seq = seq * 8 + 5;
            else if (load_dcard3) seq = seq * 8 + 6;
            if (load_pcard3) pscore = v.pf;
            if (load_dcard3 && abort) begin
                resetb = 1'b0;
                #1;
                check("abort_busy", int'(busy), 0);
                check("abort_strobe", int'(load_dcard3), 0);
                check("abort_balance", int'(balance), 100);
                check("abort_result", int'(result), 0);
                void'(sb_q.pop_back());
                model_bal = 100;
                @(negedge clk);
                resetb = 1'b1;
                ndone = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    ndone += int'(done);
                end
                check("abort_no_done", ndone, 0);
                aborted = 1;
                fin = 1;
            end else begin
                if (load_dcard3) dscore = v.df;
                if (done || bet_reject) begin
                    sb_check();
                    fin = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (!fin) begin
            check("round_timeout", 0, 1);
        end else if (!aborted) begin
            check("strobe_seq", seq, seq_exp);
            @(negedge clk);
            check("pulse_len", int'(done) + int'(bet_reject), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        resetb = 1'b0; start = 1'b0;
        bet_side = 2'b00; bet_amt = 4'd0;
        pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;

        //          side   amt  p0 d0 pc3 pf df pdr ddr res   rst
        tbl[0]  = mk(2'b01, 5,  9, 3, 0,  9, 3, 0,  0,  2'b01, 1);
        tbl[1]  = mk(2'b10, 10, 4, 4, 2,  6, 7, 1,  1,  2'b10, 1);
        tbl[2]  = mk(2'b11, 3,  7, 7, 0,  7, 7, 0,  0,  2'b11, 0);
        tbl[3]  = mk(2'b01, 3,  7, 7, 0,  7, 7, 0,  0,  2'b11, 0);
        tbl[4]  = mk(2'b01, 0,  9, 3, 0,  9, 3, 0,  0,  2'b00, 0);
        tbl[5]  = mk(2'b00, 5,  9, 3, 0,  9, 3, 0,  0,  2'b00, 0);
        tbl[6]  = mk(2'b10, 4,  6, 3, 0,  6, 9, 0,  1,  2'b10, 0);
        tbl[7]  = mk(2'b01, 2,  2, 7, 5,  9, 7, 1,  0,  2'b01, 0);
        tbl[8]  = mk(2'b10, 6,  6, 6, 0,  6, 6, 0,  0,  2'b11, 0);
        tbl[9]  = mk(2'b11, 1,  5, 3, 8,  8, 3, 1,  0,  2'b01, 0);
        tbl[10] = mk(2'b01, 7,  0, 8, 0,  0, 8, 0,  0,  2'b10, 0);
        tbl[11] = mk(2'b10, 5,  3, 6, 6,  9, 2, 1,  1,  2'b01, 0);
        tbl[12] = mk(2'b10, 5,  1, 5, 3,  4, 5, 1,  0,  2'b10, 0);
        tbl[13] = mk(2'b11, 2,  0, 0, 0,  3, 3, 1,  1,  2'b11, 0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) apply_reset();
            do_round(tbl[i], 1'b0);
        end

        // Saturation: 100 -> 220 -> 235 -> 250 -> tie +120 clipped at 255.
        apply_reset();
        do_round(mk(2'b11, 15, 7, 7, 0, 7, 7, 0, 0, 2'b11, 0), 1'b0);
        do_round(mk(2'b01, 15, 9, 0, 0, 9, 0, 0, 0, 2'b01, 0), 1'b0);
        do_round(mk(2'b01, 15, 9, 0, 0, 9, 0, 0, 0, 2'b01, 0), 1'b0);
        check("bal_250", int'(balance), 250);
        do_round(mk(2'b11, 15, 7, 7, 0, 7, 7, 0, 0, 2'b11, 0), 1'b0);
        check("bal_saturated", int'(balance), 255);

        // Drain to zero, with an over-balance wager rejected on the way.
        for (int i = 0; i < 16; i++)
            do_round(mk(2'b01, 15, 0, 9, 0, 0, 9, 0, 0, 2'b10, 0), 1'b0);
        do_round(mk(2'b01, 5, 0, 9, 0, 0, 9, 0, 0, 2'b10, 0), 1'b0);
        check("bal_10", int'(balance), 10);
        do_round(mk(2'b01, 15, 0, 9, 0, 0, 9, 0, 0, 2'b10, 0), 1'b0);
        do_round(mk(2'b01, 10, 0, 9, 0, 0, 9, 0, 0, 2'b10, 0), 1'b0);
        check("bankrupt_set", int'(bankrupt), 1);
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            busy_cnt += int'(busy) + int'(load_pcard1) + int'(bet_reject);
        end
        start = 1'b0;
        check("bankrupt_start_ignored", busy_cnt, 0);
        check("bankrupt_balance", int'(balance), 0);

        // Reset while in D3 after a winning round.
        apply_reset();
        do_round(tbl[1], 1'b0);
        check("pre_abort_balance", int'(balance), 110);
        do_round(tbl[1], 1'b1);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
